// File: rtl/rv_decode_stage.sv
// RV32I decode stage: DEPTH-entry instruction queue feeding a registered full decoder.
// Optional macro DECODE_RVE_EN restricts register fields to x0..x15 (RV32E).
package rv_define_pkg;
  typedef enum logic [4:0] {
    RV_ALU_ADD   = 5'd0,
    RV_ALU_SUB   = 5'd1,
    RV_ALU_SLL   = 5'd2,
    RV_ALU_SLT   = 5'd3,
    RV_ALU_SLTU  = 5'd4,
    RV_ALU_XOR   = 5'd5,
    RV_ALU_SRL   = 5'd6,
    RV_ALU_SRA   = 5'd7,
    RV_ALU_OR    = 5'd8,
    RV_ALU_AND   = 5'd9,
    RV_ALU_LUI   = 5'd10,
    RV_ALU_AUIPC = 5'd11,
    RV_ALU_JAL   = 5'd12,
    RV_ALU_BEQ   = 5'd13,
    RV_ALU_BNE   = 5'd14,
    RV_ALU_BLT   = 5'd15,
    RV_ALU_BGE   = 5'd16,
    RV_ALU_BLTU  = 5'd17,
    RV_ALU_BGEU  = 5'd18
  } alu_op_e;
endpackage

module rv_decode_stage #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic [31:0]            out_imm,
  output rv_define_pkg::alu_op_e out_alu_op,
  output logic                   out_use_imm,
  output logic                   out_illegal
);
  import rv_define_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        use_imm;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode_instr(input logic [31:0] ins);
    dec_t        d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    f3      = ins[14:12];
    f7      = ins[31:25];
    imm_i   = {{20{ins[31]}}, ins[31:20]};
    d.rs1     = ins[19:15];
    d.rs2     = ins[24:20];
    d.rd      = ins[11:7];
    d.imm     = 32'd0;
    d.alu_op  = RV_ALU_ADD;
    d.use_imm = 1'b0;
    d.illegal = 1'b0;
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin
        d.rs1     = 5'd0;
        d.rs2     = 5'd0;
        d.imm     = {ins[31:12], 12'd0};
        d.alu_op  = (ins[5]) ? RV_ALU_LUI : RV_ALU_AUIPC;
        d.use_imm = 1'b1;
      end
      7'b1101111: begin
        d.rs1     = 5'd0;
        d.rs2     = 5'd0;
        d.imm     = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        d.alu_op  = RV_ALU_JAL;
        d.use_imm = 1'b1;
      end
      7'b1100111: begin
        d.rs2     = 5'd0;
        d.imm     = imm_i;
        d.use_imm = 1'b1;
        d.illegal = (f3 != 3'd0);
      end
      7'b1100011: begin
        d.rd  = 5'd0;
        d.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        case (f3)
          3'b000:  d.alu_op = RV_ALU_BEQ;
          3'b001:  d.alu_op = RV_ALU_BNE;
          3'b100:  d.alu_op = RV_ALU_BLT;
          3'b101:  d.alu_op = RV_ALU_BGE;
          3'b110:  d.alu_op = RV_ALU_BLTU;
          3'b111:  d.alu_op = RV_ALU_BGEU;
          default: d.illegal = 1'b1;
        endcase
      end
      7'b0000011: begin
        d.rs2     = 5'd0;
        d.imm     = imm_i;
        d.use_imm = 1'b1;
        d.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        d.rd      = 5'd0;
        d.imm     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        d.use_imm = 1'b1;
        d.illegal = (f3[2] || (f3 == 3'b011));
      end
      7'b0010011: begin
        d.rs2     = 5'd0;
        d.imm     = imm_i;
        d.use_imm = 1'b1;
        case (f3)
          3'b000:  d.alu_op = RV_ALU_ADD;
          3'b010:  d.alu_op = RV_ALU_SLT;
          3'b011:  d.alu_op = RV_ALU_SLTU;
          3'b100:  d.alu_op = RV_ALU_XOR;
          3'b110:  d.alu_op = RV_ALU_OR;
          3'b111:  d.alu_op = RV_ALU_AND;
          3'b001: begin
            d.alu_op  = RV_ALU_SLL;
            d.illegal = (f7 != 7'h00);
          end
          3'b101: begin
            d.alu_op  = (f7 == 7'h20) ? RV_ALU_SRA : RV_ALU_SRL;
            d.illegal = (f7 != 7'h00) && (f7 != 7'h20);
          end
          default: d.illegal = 1'b1;
        endcase
      end
      7'b0110011: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'b000:  d.alu_op = RV_ALU_ADD;
            3'b001:  d.alu_op = RV_ALU_SLL;
            3'b010:  d.alu_op = RV_ALU_SLT;
            3'b011:  d.alu_op = RV_ALU_SLTU;
            3'b100:  d.alu_op = RV_ALU_XOR;
            3'b101:  d.alu_op = RV_ALU_SRL;
            3'b110:  d.alu_op = RV_ALU_OR;
            default: d.alu_op = RV_ALU_AND;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'b000) begin
          d.alu_op = RV_ALU_SUB;
        end else if (f7 == 7'h20 && f3 == 3'b101) begin
          d.alu_op = RV_ALU_SRA;
        end else begin
          d.illegal = 1'b1;
        end
      end
      // FENCE is a NOP; only ECALL/EBREAK are accepted in the SYSTEM space.
      7'b0001111, 7'b1110011: begin
        d.rs1     = 5'd0;
        d.rs2     = 5'd0;
        d.rd      = 5'd0;
        d.illegal = (ins[4]) ? ((ins[31:7] != 25'd0) && (ins[31:7] != 25'h0002000))
                             : (f3 != 3'd0);
      end
      default: d.illegal = 1'b1;
    endcase
`ifdef DECODE_RVE_EN
    if (d.rs1[4] || d.rs2[4] || d.rd[4]) begin
      d.illegal = 1'b1;
    end
`endif
    if (d.illegal) begin
      d.rs1     = 5'd0;
      d.rs2     = 5'd0;
      d.rd      = 5'd0;
      d.imm     = 32'd0;
      d.alu_op  = RV_ALU_ADD;
      d.use_imm = 1'b0;
    end
    return d;
  endfunction

  logic [31:0]     instr_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  dec_t            out_q, out_d, dec_s;
  logic            push_s, pop_s;

  assign in_ready = !reset && (count_q < CNT_W'(DEPTH));
  assign push_s   = in_valid && in_ready && !flush;
  assign pop_s    = (!out_valid_q || out_ready) && (count_q != '0);
  assign dec_s    = decode_instr(instr_mem_q[rd_ptr_q]);

  // Queue pointer/occupancy next state; flush empties everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Output register: reload from the queue head whenever it is empty or being consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (pop_s) begin
      out_valid_d = 1'b1;
      out_pc_d    = pc_mem_q[rd_ptr_q];
      out_d       = dec_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Storage array is data-only; occupancy tracking makes stale entries harmless.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_q       <= out_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_alu_op  = out_q.alu_op;
  assign out_use_imm = out_q.use_imm;
  assign out_illegal = out_q.illegal;

endmodule
